// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and fetch entry type for the fetch stage
package fetch_pkg;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, clear, count and head outputs
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (push && !clear && wr_q == AW'(i)) ? din : mem_q[i];
    wr_d = clear ? '0 : wr_q + AW'(push);
    rd_d = clear ? '0 : rd_q + AW'(pop);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign count = cnt_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fixed-latency imem requests, redirect flush and decode handshake; FETCH_STATS_EN adds stall_cnt
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_STATS_EN
  ,output logic [15:0]       stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic req, pop, push;
  logic [ADDR_W+INSTR_W-1:0] head;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redirect;
  assign push = inflight_q && !redirect;
  // occupancy counts the in-flight response so a request never overflows the FIFO
  assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign req = reset_ && !redirect && occ < (CW+1)'(DEPTH);
  always_comb begin
    pc_d = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : req ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    inflight_d = req;
    tag_d = req ? pc_q : tag_q;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_fifo (
    .clk(clk),
    .reset_(reset_),
    .push(push),
    .pop(pop),
    .clear(redirect),
    .din({tag_q, imem_rdata}),
    .count(count),
    .head(head)
  );
  assign imem_req = req;
  assign imem_addr = pc_q;
  assign out_pc = out_valid ? head[INSTR_W +: ADDR_W] : '0;
  assign out_instr = out_valid ? head[INSTR_W-1:0] : '0;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (out_valid && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule
